// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, sequencer state type and latency constants.
// Optional feature macro (consumed by muldiv_sequencer): MULDIV_UNSIGNED_EN.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned MULDIV_LATENCY = DEFAULT_WIDTH + 2;

    // Start-to-done latency for an arbitrary operand width.
    function automatic int unsigned muldiv_latency(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs
// Combinational conditional two's-complement: result = negate ? -value : value.
// Used both to take operand magnitudes and to re-apply result signs.
// Ports:
//   value  - input operand (W bits)
//   negate - when high, the two's complement of value is produced
//   result - conditionally negated value (W bits)
module muldiv_abs
    import muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ('0 - value) : value;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative multiply/divide unit for the multicycle MIPS core. A single
// shift-add / restoring-subtract engine works on operand magnitudes for
// WIDTH cycles, a FIX cycle re-applies signs and writes HI/LO, and a DONE
// cycle pulses done. Divide by zero skips straight to DONE with div_zero.
// Latency: WIDTH+2 cycles from the cycle start is accepted.
// Optional feature: define MULDIV_UNSIGNED_EN to make op[1] select unsigned
// operation (MULTU/DIVU); otherwise every op is treated as signed.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset
//   start    - request pulse, accepted only in IDLE
//   op       - 00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//   a, b     - operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   hi, lo   - HI/LO result registers
//   busy     - high in MULT, DIV and FIX
//   done     - one-cycle pulse when hi/lo updated or on divide-by-zero
//   div_zero - one-cycle pulse with done on a divide by zero
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic               is_div_q;
    logic               neg_quot_q;   // product / quotient sign
    logic               neg_rem_q;    // remainder follows the dividend
    logic               dz_q;
    logic [WIDTH-1:0]   opnd_q;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;        // {partial/remainder, multiplier/quotient}

    // ---------------- operand decode ----------------
    logic signed_op;
    logic is_div;

`ifdef MULDIV_UNSIGNED_EN
    assign signed_op = ~op[1];
`else
    logic unused_op_msb;
    assign unused_op_msb = op[1];
    assign signed_op     = 1'b1;
`endif

    assign is_div = op[0];

    logic sign_a;
    logic sign_b;
    logic div_by_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign sign_a      = signed_op & a[WIDTH-1];
    assign sign_b      = signed_op & b[WIDTH-1];
    assign div_by_zero = is_div && (b == '0);

    muldiv_abs #(.W(WIDTH)) u_abs_a (.value(a), .negate(sign_a), .result(mag_a));
    muldiv_abs #(.W(WIDTH)) u_abs_b (.value(b), .negate(sign_b), .result(mag_b));

    // ---------------- engine step ----------------
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_diff;
    logic           div_fits;
    logic           last_iter;

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit (acc LSB) is set; the carry lands in the shift.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Restoring divide: trial-subtract divisor from {rem, next dividend bit}.
        // The difference always lies in (-2^WIDTH, 2^WIDTH), so its MSB is the sign.
        div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        div_fits = ~div_diff[WIDTH];
    end

    assign last_iter = (count == CW'(WIDTH - 1));

    // ---------------- sign fix ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_abs #(.W(2*WIDTH)) u_fix_prod (.value(acc_q), .negate(neg_quot_q), .result(prod_fix));
    muldiv_abs #(.W(WIDTH)) u_fix_quot (.value(acc_q[WIDTH-1:0]), .negate(neg_quot_q), .result(quot_fix));
    muldiv_abs #(.W(WIDTH)) u_fix_rem (.value(acc_q[2*WIDTH-1:WIDTH]), .negate(neg_rem_q), .result(rem_fix));

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (div_by_zero) begin
                        state_next = DONE;
                    end else if (is_div) begin
                        state_next = DIV;
                    end else begin
                        state_next = MULT;
                    end
                end
            end
            MULT: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                div_zero   = dz_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            is_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count      <= '0;
                        is_div_q   <= is_div;
                        neg_quot_q <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
                        dz_q       <= div_by_zero;
                        opnd_q     <= is_div ? mag_b : mag_a;
                        acc_q      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    end
                end
                MULT: begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                DIV: begin
                    acc_q <= div_fits
                           ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_div_q) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own sequencer for the multicycle MIPS core. Implements MULT/DIV, plus MULTU/DIVU when the optional feature is compiled in.
- Operands come from the A/B registers; results go to HI/LO registers held inside this block.
- The main control FSM pulses start, then holds its state until done, which it uses as a stall release.
- One iterative shift-add / restoring-subtract engine is shared by both operations.

Parameters:
- WIDTH, 32, operand width. Iteration count = WIDTH. Total latency = WIDTH+2 cycles.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request pulse; accepted only in IDLE.
- op  input  2  operation: 00 MULT, 01 DIV, 10 MULTU, 11 DIVU.
- a  input  WIDTH  operand A: multiplicand or dividend (from A register).
- b  input  WIDTH  operand B: multiplier or divisor (from B register).
- hi  output  WIDTH  HI register: product[63:32] or remainder.
- lo  output  WIDTH  LO register: product[31:0] or quotient.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo are updated, or on the divide-by-zero abort.
- div_zero  output  1  one-cycle pulse, coincident with done, on a divide with b==0.

Behaviour:
- Reset (synchronous): state=IDLE; hi=lo=0; busy=done=div_zero=0. Reset mid-operation abandons the operation. No partial result is written. start is accepted from the cycle after reset deasserts.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE, start=1 (cycle 0):
  - Latch op, the sign flags of a and b, |a| and |b| (magnitudes taken only for signed ops).
  - Clear the iteration counter. Go to MULT or DIV.
- Divide by zero: DIV op with b==0 goes IDLE->DONE directly.
  - DONE cycle (cycle 1): done=1, div_zero=1.
  - hi/lo unchanged.
- MULT (cycles 1..WIDTH): shift-add on magnitudes into a 2*WIDTH accumulator, one multiplier bit per cycle. The counter reaching WIDTH-1 goes to FIX.
- DIV (cycles 1..WIDTH): restoring division on magnitudes, one quotient bit per cycle; remainder WIDTH+1 bits internally. The counter reaching WIDTH-1 goes to FIX.
- FIX (cycle WIDTH+1): apply signs, then write hi/lo.
  - Product negated if sign(a)^sign(b).
  - Quotient negated if sign(a)^sign(b): truncation toward zero.
  - Remainder negated if sign(a): remainder takes the dividend's sign.
- DONE (cycle WIDTH+2): done=1 for exactly one cycle; hi/lo are visible. Goes unconditionally to IDLE.
- busy: 1 in MULT, DIV, FIX; 0 in IDLE and DONE.
- start outside IDLE (including in DONE) is ignored. Inputs a, b, op are don't-care after cycle 0.
- hi/lo hold their value until the next completed operation. A divide-by-zero leaves them unchanged.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- The magnitude of 0x80000000 is 0x80000000, treated as unsigned inside the engine.
- No arithmetic exceptions other than div_zero.

Optional Feature:
- Macro MULDIV_UNSIGNED_EN.
- Defined: op[1]=1 selects unsigned. Magnitude and FIX negation are bypassed, so operands are used raw and the result is written raw.
- Undefined: op[1] is ignored, and all ops are signed MULT/DIV. Sign logic stays active for every op.
- Latency is identical in both builds.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT=2'b00, OP_DIV=2'b01, OP_MULTU=2'b10, OP_DIVU=2'b11.
  - State enum IDLE/MULT/DIV/FIX/DONE.
  - Constant MULDIV_LATENCY = WIDTH+2.
- Sub-module muldiv_abs: combinational conditional two's-complement, parameterised width.
  - Used for operand magnitude (WIDTH) and for result sign fix (WIDTH and 2*WIDTH).

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3): done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done at cycle 34, div_zero=0.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22: done=div_zero=1 at cycle 1; hi/lo stay 0x11/0x22; busy never asserted.
- MULT a=b=0x80000000, second start pulsed at cycle 10: hi=0x40000000, lo=0; the second start is ignored and done pulses only once.
- Start DIV 100/7, reset at cycle 10: next cycle hi=lo=0, busy=0. A fresh DIV 100/7 gives lo=14, hi=2 at its cycle 34.
- Unsigned, with MULDIV_UNSIGNED_EN:
  - MULTU a=0xFFFFFFFF, b=2: hi=1, lo=0xFFFFFFFE.
  - DIVU a=0xFFFFFFFF, b=16: lo=0x0FFFFFFF, hi=0xF.
  - Without the macro, the same MULTU gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.
